// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates and the reset-divisor helper.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ   = 100000000;
    localparam int unsigned DEF_BAUD       = 19200;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef struct packed {
        logic [31:0] int_part;
        logic [31:0] frac_part;
    } div_t;

    // 64-bit math because clk_freq << frac_w overflows 32 bits at typical rates.
    function automatic div_t calc_div_rst(input longint clk_freq, input longint baud,
                                          input longint oversample, input int frac_w);
        longint full;
        div_t   d;
        full        = (clk_freq << frac_w) / (baud * oversample);
        d.int_part  = 32'(full >> frac_w);
        d.frac_part = 32'(full & ((longint'(1) << frac_w) - 1));
        return d;
    endfunction

endpackage

// File: rtl/frac_period_counter.sv
// Cycle counter with fractional phase accumulator; flags the last cycle of each period.
module frac_period_counter #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              restart,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              boundary
);

    logic [INT_W:0]  count;
    logic [INT_W:0]  last;
    logic [FRAC_W-1:0] acc;
    logic            carry;
    logic [FRAC_W:0] sum;

    // Period length is div_int plus the carry left by the previous accumulator update.
    assign last     = {1'b0, div_int} + {{INT_W{1'b0}}, carry} - {{INT_W{1'b0}}, 1'b1};
    assign sum      = {1'b0, acc} + {1'b0, div_frac};
    assign boundary = run && (count == last);

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (boundary) begin
            count <= '0;
            if (restart) begin
                acc   <= '0;
                carry <= 1'b0;
            end else begin
                acc   <= sum[FRAC_W-1:0];
                carry <= sum[FRAC_W];
            end
        end else begin
            count <= count + {{INT_W{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-divisor UART baud generator: oversample and bit ticks from a loadable divisor.
// Define BAUD_GEN_SYNC_EN to add the i_sync input for RX start-bit alignment.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned DEFAULT_BAUD = DEF_BAUD,
    parameter int unsigned OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int          INT_W        = 16,
    parameter int          FRAC_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [INT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
`ifdef BAUD_GEN_SYNC_EN
    input  logic              i_sync,
`endif
    output logic              o_os_tick,
    output logic              o_bit_tick,
    output logic              o_load_ack,
    output logic              o_div_err,
    output logic [INT_W-1:0]  o_div_int,
    output logic [FRAC_W-1:0] o_div_frac
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam div_t DIV_RST = calc_div_rst(longint'(CLK_FREQ), longint'(DEFAULT_BAUD),
                                            longint'(OVERSAMPLE), FRAC_W);
    localparam logic [INT_W-1:0]  RST_INT  = DIV_RST.int_part[INT_W-1:0];
    localparam logic [FRAC_W-1:0] RST_FRAC = DIV_RST.frac_part[FRAC_W-1:0];
    localparam logic [INT_W-1:0]  MIN_INT  = INT_W'(2);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

    logic [INT_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic              pending;
    logic [OS_W-1:0]   os_cnt;
    logic              sync_req;
    logic              run;
    logic              boundary;
    logic              apply;

`ifdef BAUD_GEN_SYNC_EN
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);
    assign sync_req = i_sync;
`else
    assign sync_req = 1'b0;
`endif

    assign run = i_valid && !sync_req;
    // A new divisor only takes effect between periods, or immediately while idle.
    assign apply = pending && (!i_valid || boundary);

    frac_period_counter #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_period (
        .clk      (i_clk),
        .reset    (i_reset),
        .run      (run),
        .restart  (apply),
        .div_int  (o_div_int),
        .div_frac (o_div_frac),
        .boundary (boundary)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_os_tick   <= 1'b0;
            o_bit_tick  <= 1'b0;
            o_load_ack  <= 1'b0;
            o_div_err   <= 1'b0;
            o_div_int   <= RST_INT;
            o_div_frac  <= RST_FRAC;
            shadow_int  <= RST_INT;
            shadow_frac <= RST_FRAC;
            pending     <= 1'b0;
            os_cnt      <= '0;
        end else begin
            o_os_tick  <= boundary;
            o_bit_tick <= boundary && (os_cnt == OS_LAST);
            o_load_ack <= apply;
            o_div_err  <= i_div_load && (i_div_int < MIN_INT);

            if (!i_valid) begin
                os_cnt <= '0;
`ifdef BAUD_GEN_SYNC_EN
            end else if (sync_req) begin
                os_cnt <= OS_HALF;
`endif
            end else if (boundary) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end

            if (apply) begin
                o_div_int  <= shadow_int;
                o_div_frac <= shadow_frac;
            end

            // A load in the same cycle as an apply stays pending for the next boundary.
            if (i_div_load) begin
                shadow_int  <= (i_div_int < MIN_INT) ? MIN_INT : i_div_int;
                shadow_frac <= i_div_frac;
                pending     <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised successor to the fixed-divisor UART baud tick generator. Produces an oversample tick and a bit tick from one clock. Divisor is runtime-loadable, with an integer part and a fractional part (phase accumulator), so non-integer clock/baud ratios average out exactly. Sits between the register/control block and the UART RX/TX engines; one instance serves one RX/TX pair.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz (used only for the reset divisor)
DEFAULT_BAUD, 19200, baud rate selected at reset
OVERSAMPLE, 16, oversample ticks per bit; power of two, 4..64
INT_W, 16, width of integer divisor part
FRAC_W, 8, width of fractional divisor part

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  enable; low clears counters and suppresses ticks
i_div_int  in  INT_W  integer cycles per oversample tick
i_div_frac  in  FRAC_W  fractional cycles per oversample tick, in units of 2^-FRAC_W
i_div_load  in  1  one-cycle strobe; captures i_div_int/i_div_frac into the shadow register
o_os_tick  out  1  one-cycle oversample tick
o_bit_tick  out  1  one-cycle tick, once every OVERSAMPLE oversample ticks
o_load_ack  out  1  one-cycle pulse when the shadow divisor becomes active
o_div_err  out  1  one-cycle pulse when a loaded i_div_int < 2 was clamped
o_div_int  out  INT_W  active integer divisor (readback)
o_div_frac  out  FRAC_W  active fractional divisor (readback)

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_reset) is synchronous, active-high.
- Reset values:
  - All tick, ack and error outputs 0.
  - Cycle counter, fractional accumulator and oversample counter 0; shadow pending flag 0.
  - Active and shadow divisor set to DIV_RST = CLK_FREQ*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE), integer division: int = DIV_RST >> FRAC_W, frac = low FRAC_W bits. Defaults give 83333: int 325, frac 133.
- Period generation (i_valid=1):
  - The cycle counter counts 0..P-1, where P = active int + c and c = carry held from the last accumulator update.
  - On the cycle counter == P-1: counter <= 0; o_os_tick <= 1 on the next edge (registered, one-cycle latency); acc <= (acc + frac) mod 2^FRAC_W; c <= carry-out of that add.
  - Long-run mean period = int + frac/2^FRAC_W cycles, exact.
  - First o_os_tick after i_valid rises: int cycles later (acc = 0, c = 0).
- Bit tick:
  - The oversample counter increments on each os tick and wraps at OVERSAMPLE-1.
  - o_bit_tick asserts in the same cycle as the os tick that wraps it to 0. The first bit tick is the OVERSAMPLE-th os tick.
- i_valid=0: counter, acc, c and the oversample counter are held at 0; all ticks 0. Divisor registers and the pending shadow are retained.
- Divisor load:
  - i_div_load captures the inputs into shadow and sets pending.
  - If i_div_int < 2, shadow int = 2 and o_div_err pulses on the next cycle.
  - Pending shadow is copied to active only at a period boundary, i.e. the same edge the counter wraps to 0, so a period never mixes divisors. On that copy: acc and c clear, o_load_ack pulses with the same latency as o_os_tick, and pending clears.
  - If i_valid=0 when pending, the copy happens on the next cycle.
  - A second load before apply overwrites the shadow; only one ack is issued.
  - Load on the same cycle as a boundary: the boundary uses the old shadow state; the new value applies at the following boundary.
- Reset mid-period: takes priority over everything. The pending load is discarded and the divisor returns to DIV_RST.
- Widths: acc is FRAC_W+1 bits internally for carry. Counter is INT_W+1 bits so int+1 never overflows. Readbacks show the active divisor, not the shadow.

Optional Feature:
- Macro: BAUD_GEN_SYNC_EN.
- Defined: adds input i_sync (1 bit). When i_sync=1 and i_valid=1:
  - counter, acc and c clear;
  - the oversample counter loads OVERSAMPLE/2, so the next o_bit_tick falls mid-bit for RX start-bit alignment;
  - no tick is emitted in that cycle.
  - i_sync has priority over period wrap; a pending load is still applied at the next boundary.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - localparams for the default CLK_FREQ/DEFAULT_BAUD/OVERSAMPLE;
  - a function computing DIV_RST split into int and frac;
  - a divisor struct typedef {int, frac}.
- One natural sub-module, frac_period_counter: cycle counter plus accumulator, emitting a boundary strobe. The top level holds shadow/load logic and the oversample counter.

Test Plan:
- Reset release with defaults, i_valid=1: o_div_int=325, o_div_frac=133. Over 256 os ticks, total cycles = 83333 ±1. o_bit_tick count = 16.
- Load int=4, frac=0, OVERSAMPLE=4, then i_valid=1: os tick every 4 cycles, bit tick every 16 cycles, coincident with every 4th os tick.
- int=4, frac=128 (FRAC_W=8): os periods alternate 4,5,4,5; 20 ticks span 90 cycles.
- Running at int=4; load int=6 two cycles into a period: current period stays 4, o_load_ack pulses with that tick, following periods are 6.
- Load int=1: o_div_err pulses once, o_div_int reads 2, os tick every 2 cycles. i_reset mid-period: all outputs 0 next cycle, divisor back to 325/133.
- (BAUD_GEN_SYNC_EN) int=4, OVERSAMPLE=16: pulse i_sync; the first o_bit_tick arrives 8 os ticks (32 cycles) later, then every 64 cycles.
